// File: rtl/hack_cpu_ctrl_if.sv
// Data-memory req/ack bus between the Hack CPU control stage and data RAM.
interface hack_cpu_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/register stage: fetch, decode, M read, execute, M write.
// Optional self-jump halt detection is enabled by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    output logic [14:0]            imem_addr,
    input  logic [15:0]            instr,
    hack_cpu_ctrl_if.master        dmem,
    output logic [15:0]            alu_x,
    output logic [15:0]            alu_y,
    output logic                   alu_zx,
    output logic                   alu_nx,
    output logic                   alu_zy,
    output logic                   alu_ny,
    output logic                   alu_f,
    output logic                   alu_no,
    input  logic [15:0]            alu_out,
    input  logic                   alu_zr,
    input  logic                   alu_ng,
    output logic [15:0]            a_out,
    output logic [15:0]            d_out,
    output logic [14:0]            pc_out,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MREAD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MWRITE = 3'd4
`ifdef HACK_CPU_HALT_DETECT_EN
        , S_HALT = 3'd5
`endif
    } state_t;

    state_t      r_state, w_nstate;
    logic [15:0] r_a, r_d, r_ir, r_m, r_wdata;
    logic [14:0] r_pc, r_waddr;
    logic        w_jump;
    logic        w_self;
    logic [14:0] w_pc_inc;
`ifdef HACK_CPU_HALT_DETECT_EN
    logic        r_halt_pend;
`endif

    always_comb begin
        w_nstate = r_state;
        w_pc_inc = r_pc + 15'd1;
        w_jump   = (r_ir[2] & alu_ng) | (r_ir[1] & alu_zr) | (r_ir[0] & ~alu_ng & ~alu_zr);
        w_self   = w_jump && (r_a[14:0] == r_pc);
        case (r_state)
            S_FETCH:  w_nstate = S_DECODE;
            S_DECODE: begin
                if (!r_ir[15])     w_nstate = S_FETCH;
                else if (r_ir[12]) w_nstate = S_MREAD;
                else               w_nstate = S_EXEC;
            end
            S_MREAD:  if (dmem.dmem_ack) w_nstate = S_EXEC;
            S_EXEC: begin
                if (r_ir[3]) w_nstate = S_MWRITE;
`ifdef HACK_CPU_HALT_DETECT_EN
                else if (w_self) w_nstate = S_HALT;
`endif
                else w_nstate = S_FETCH;
            end
            S_MWRITE: begin
                if (dmem.dmem_ack) begin
`ifdef HACK_CPU_HALT_DETECT_EN
                    w_nstate = r_halt_pend ? S_HALT : S_FETCH;
`else
                    w_nstate = S_FETCH;
`endif
                end
            end
`ifdef HACK_CPU_HALT_DETECT_EN
            S_HALT:   w_nstate = S_HALT;
`endif
            default:  w_nstate = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_a     <= '0;
            r_d     <= '0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_m     <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef HACK_CPU_HALT_DETECT_EN
            r_halt_pend <= 1'b0;
`endif
        end else begin
            r_state <= w_nstate;
            case (r_state)
                S_FETCH:  r_ir <= instr;
                S_DECODE: begin
                    if (!r_ir[15]) begin
                        r_a  <= {1'b0, r_ir[14:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                S_MREAD:  if (dmem.dmem_ack) r_m <= dmem.dmem_rdata;
                S_EXEC: begin
                    // all destinations and the jump target see the pre-edge A
                    if (r_ir[5]) r_a <= alu_out;
                    if (r_ir[4]) r_d <= alu_out;
                    if (r_ir[3]) begin
                        r_waddr <= r_a[14:0];
                        r_wdata <= alu_out;
                    end
                    r_pc <= w_jump ? r_a[14:0] : w_pc_inc;
`ifdef HACK_CPU_HALT_DETECT_EN
                    r_halt_pend <= w_self;
`endif
                end
                default: ;
            endcase
        end
    end

    assign imem_addr       = r_pc;
    assign dmem.dmem_req   = (r_state == S_MREAD) || (r_state == S_MWRITE);
    assign dmem.dmem_we    = (r_state == S_MWRITE);
    assign dmem.dmem_addr  = (r_state == S_MWRITE) ? r_waddr : r_a[14:0];
    assign dmem.dmem_wdata = r_wdata;

    assign alu_x  = r_d;
    assign alu_y  = r_ir[12] ? r_m : r_a;
    assign alu_zx = r_ir[11];
    assign alu_nx = r_ir[10];
    assign alu_zy = r_ir[9];
    assign alu_ny = r_ir[8];
    assign alu_f  = r_ir[7];
    assign alu_no = r_ir[6];

    assign a_out  = r_a;
    assign d_out  = r_d;
    assign pc_out = r_pc;
`ifdef HACK_CPU_HALT_DETECT_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: directed vector table, corner sequences, and a random
// program run against an instruction-level Hack ISA model.
module tb_hack_cpu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] imem_addr;
    logic [15:0] instr;
    logic [15:0] alu_x, alu_y, alu_out, a_out, d_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] pc_out;
    logic        halted;

    hack_cpu_ctrl_if dif ();

    hack_cpu_ctrl dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .instr(instr), .dmem(dif),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
        .alu_zr(alu_zr), .alu_ng(alu_ng), .a_out(a_out), .d_out(d_out),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return {(o == 16'h0), o[15], o};
    endfunction

    logic [15:0] rom  [0:32767];
    logic [15:0] dmem [0:32767];
    int          ack_wait = 0;
    int          cnt = 0;

    assign instr = rom[imem_addr];
    assign {alu_zr, alu_ng, alu_out} = hack_alu(alu_x, alu_y,
                                      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign dif.dmem_ack   = dif.dmem_req && (cnt >= ack_wait);
    assign dif.dmem_rdata = dmem[dif.dmem_addr];

    always @(posedge clk) begin
        if (reset || !dif.dmem_req || dif.dmem_ack) cnt <= 0;
        else cnt <= cnt + 1;
        if (!reset && dif.dmem_req && dif.dmem_we && dif.dmem_ack)
            dmem[dif.dmem_addr] <= dif.dmem_wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bus must hold address/direction/data while a request waits for ack
    logic        s_pend = 1'b0;
    logic        s_we;
    logic [14:0] s_addr;
    logic [15:0] s_wdata;
    initial forever begin
        @(negedge clk);
        if (s_pend) begin
            chk("bus_req_held", {31'd0, dif.dmem_req}, 32'd1);
            chk("bus_addr_stable", {17'd0, dif.dmem_addr}, {17'd0, s_addr});
            chk("bus_we_stable", {31'd0, dif.dmem_we}, {31'd0, s_we});
            if (s_we) chk("bus_wdata_stable", {16'd0, dif.dmem_wdata}, {16'd0, s_wdata});
        end
        s_pend  = dif.dmem_req && !dif.dmem_ack && !reset;
        s_we    = dif.dmem_we;
        s_addr  = dif.dmem_addr;
        s_wdata = dif.dmem_wdata;
    end

    typedef struct {
        logic [15:0] ins;
        int          wt;
        logic        pre_en;
        logic [14:0] pre_addr;
        logic [15:0] pre_data;
        logic        chk_ctrl;
        logic [5:0]  exp_ctrl;
        int          cyc;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
        logic [14:0] exp_pc;
    } vec_t;

    vec_t vt [15];

    logic [15:0] m_a, m_d, m_y, m_out, m_ins;
    logic [14:0] m_pc;
    logic [15:0] m_mem [0:32767];
    logic        m_zr, m_ng, m_jmp, m_halt;
    int          m_cyc;
    logic        m_wr;
    logic [14:0] m_waddr;

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [14:0] cur_pc;
        vt[0]  = '{16'h0005, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd5,  16'd0,      15'd1};
        vt[1]  = '{16'hEC10, 0, 1'b0, 15'd0, 16'h0,    1'b1, 6'b110000, 3, 16'd5,  16'd5,      15'd2};
        vt[2]  = '{16'h0007, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd7,  16'd5,      15'd3};
        vt[3]  = '{16'hE308, 3, 1'b0, 15'd0, 16'h0,    1'b1, 6'b001100, 7, 16'd7,  16'd5,      15'd4};
        vt[4]  = '{16'h0007, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd7,  16'd5,      15'd5};
        vt[5]  = '{16'hFC10, 0, 1'b1, 15'd7, 16'h1234, 1'b0, 6'b000000, 4, 16'd7,  16'h1234,   15'd6};
        vt[6]  = '{16'h000A, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd10, 16'h1234,   15'd7};
        vt[7]  = '{16'hEA87, 0, 1'b0, 15'd0, 16'h0,    1'b1, 6'b101010, 3, 16'd10, 16'h1234,   15'd10};
        vt[8]  = '{16'hEA90, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 3, 16'd10, 16'd0,      15'd11};
        vt[9]  = '{16'h0014, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd20, 16'd0,      15'd12};
        vt[10] = '{16'hE302, 0, 1'b0, 15'd0, 16'h0,    1'b1, 6'b001100, 3, 16'd20, 16'd0,      15'd20};
        vt[11] = '{16'h0005, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd5,  16'd0,      15'd21};
        vt[12] = '{16'hEC10, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 3, 16'd5,  16'd5,      15'd22};
        vt[13] = '{16'h001E, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 2, 16'd30, 16'd5,      15'd23};
        vt[14] = '{16'hE302, 0, 1'b0, 15'd0, 16'h0,    1'b0, 6'b000000, 3, 16'd30, 16'd5,      15'd24};

        for (int i = 0; i < 32768; i++) begin
            rom[i]  = 16'h0;
            dmem[i] <= 16'h0;
        end
        do_reset();

        chk("rst_pc", {17'd0, pc_out}, 32'd0);
        chk("rst_a", {16'd0, a_out}, 32'd0);
        chk("rst_d", {16'd0, d_out}, 32'd0);
        chk("rst_req", {31'd0, dif.dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dif.dmem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);

        cur_pc = 15'd0;
        for (int i = 0; i < 15; i++) begin
            int done;
            rom[cur_pc] = vt[i].ins;
            ack_wait    = vt[i].wt;
            if (vt[i].pre_en) dmem[vt[i].pre_addr] <= vt[i].pre_data;
            done = 0;
            if (vt[i].chk_ctrl) begin
                tick();
                tick();
                done = 2;
                chk($sformatf("v%0d_ctrl", i),
                    {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                    {26'd0, vt[i].exp_ctrl});
            end
            while (done < vt[i].cyc) begin
                tick();
                done++;
                if (!vt[i].ins[15]) chk($sformatf("v%0d_noreq", i), {31'd0, dif.dmem_req}, 32'd0);
            end
            chk($sformatf("v%0d_a", i), {16'd0, a_out}, {16'd0, vt[i].exp_a});
            chk($sformatf("v%0d_d", i), {16'd0, d_out}, {16'd0, vt[i].exp_d});
            chk($sformatf("v%0d_pc", i), {17'd0, pc_out}, {17'd0, vt[i].exp_pc});
            if (vt[i].ins == 16'hE308) chk("v_mwrite_mem7", {16'd0, dmem[7]}, 32'd5);
            cur_pc = vt[i].exp_pc;
        end

        // reset in the middle of a stalled write
        rom[cur_pc] = 16'hE308;
        ack_wait = 10;
        tick(); tick(); tick();
        chk("mw_req", {31'd0, dif.dmem_req}, 32'd1);
        chk("mw_we", {31'd0, dif.dmem_we}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mw_rst_req", {31'd0, dif.dmem_req}, 32'd0);
        chk("mw_rst_pc", {17'd0, pc_out}, 32'd0);
        reset = 1'b0;
        ack_wait = 0;

        // self-loop jump at PC 3
        for (int i = 0; i < 8; i++) rom[i] = 16'h0;
        rom[2] = 16'h0003;
        rom[3] = 16'hEA87;
        do_reset();
        repeat (9) tick();
        chk("self_pc", {17'd0, pc_out}, 32'd3);
`ifdef HACK_CPU_HALT_DETECT_EN
        chk("self_halted", {31'd0, halted}, 32'd1);
`else
        chk("self_halted", {31'd0, halted}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("self_pc_hold", {17'd0, pc_out}, 32'd3);
            chk("self_req", {31'd0, dif.dmem_req}, 32'd0);
        end

        // random program against the ISA model
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] r;
            if ($urandom_range(0, 1) == 0) rom[i] = {1'b0, 8'd0, 7'($urandom_range(0, 127))};
            else                           rom[i] = {3'b111, 13'($urandom)};
            r = 16'($urandom);
            dmem[i] <= r;
            m_mem[i] = r;
        end
        do_reset();
        m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0; m_halt = 1'b0;
        for (int k = 0; k < 400 && !m_halt; k++) begin
            ack_wait = $urandom_range(0, 3);
            m_ins = rom[m_pc];
            m_wr  = 1'b0;
            m_waddr = m_a[14:0];
            if (!m_ins[15]) begin
                m_cyc = 2;
                m_a   = {1'b0, m_ins[14:0]};
                m_pc  = m_pc + 15'd1;
            end else begin
                m_y = m_ins[12] ? m_mem[m_a[14:0]] : m_a;
                {m_zr, m_ng, m_out} = hack_alu(m_d, m_y, m_ins[11:6]);
                m_jmp = (m_ins[2] && m_ng) || (m_ins[1] && m_zr) || (m_ins[0] && !m_ng && !m_zr);
                m_cyc = 3 + (m_ins[12] ? 1 + ack_wait : 0) + (m_ins[3] ? 1 + ack_wait : 0);
`ifdef HACK_CPU_HALT_DETECT_EN
                if (m_jmp && (m_a[14:0] == m_pc)) m_halt = 1'b1;
`endif
                if (m_ins[3]) begin
                    m_wr = 1'b1;
                    m_mem[m_waddr] = m_out;
                end
                m_pc = m_jmp ? m_a[14:0] : m_pc + 15'd1;
                if (m_ins[5]) m_a = m_out;
                if (m_ins[4]) m_d = m_out;
            end
            repeat (m_cyc) tick();
            chk($sformatf("rnd%0d_a", k), {16'd0, a_out}, {16'd0, m_a});
            chk($sformatf("rnd%0d_d", k), {16'd0, d_out}, {16'd0, m_d});
            chk($sformatf("rnd%0d_pc", k), {17'd0, pc_out}, {17'd0, m_pc});
            chk($sformatf("rnd%0d_halted", k), {31'd0, halted}, {31'd0, m_halt});
            if (m_wr) chk($sformatf("rnd%0d_mem", k), {16'd0, dmem[m_waddr]}, {16'd0, m_mem[m_waddr]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle control/register stage of the Hack CPU, sitting directly upstream and downstream of the 16-bit Hack ALU. It fetches instructions, holds the A, D and PC registers, drives the ALU operands and six control bits, and writes the ALU result back. It also performs data-memory reads and writes over a req/ack handshake and resolves jumps from the ALU `zr`/`ng` flags.

## Interface
- No parameters. Data width is 16; address width is 15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out 15: instruction address, equal to PC.
- `instr` in 16: ROM data; combinational read of `imem_addr`.
- `dmem_req` out 1: data-memory request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 15: data-memory address.
- `dmem_wdata` out 16: write data.
- `dmem_rdata` in 16: read data, valid when `dmem_ack`=1.
- `dmem_ack` in 1: completes the current request; sampled only while `dmem_req`=1.
- `alu_x` out 16: ALU operand x, equal to D.
- `alu_y` out 16: ALU operand y; M_reg when IR[12]=1, else A.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no` out 1 each: equal to IR[11:6] in that order.
- `alu_out` in 16; `alu_zr` in 1; `alu_ng` in 1: ALU result and flags.
- `a_out`, `d_out` out 16; `pc_out` out 15: architectural state, for verification.
- `halted` out 1: halt-detect flag (see Configuration).

## Operation
- Registers: A[15:0], D[15:0], PC[14:0], IR[15:0], M_reg[15:0], waddr[14:0], wdata[15:0], state.
- The FSM has six states:
  - FETCH: IR <= `instr`; go to DECODE.
  - DECODE, A-instruction (IR[15]=0): A <= {1'b0, IR[14:0]}, PC <= PC+1, go to FETCH.
  - DECODE, C-instruction: go to MREAD if IR[12]=1, else to EXECUTE.
  - MREAD: `dmem_req`=1, `dmem_we`=0, `dmem_addr`=A[14:0]. On ack, M_reg <= `dmem_rdata` and go to EXECUTE. Otherwise hold.
  - EXECUTE: the ALU is combinationally driven from IR, D and A/M_reg.
    - IR[5]: A <= `alu_out`.
    - IR[4]: D <= `alu_out`.
    - IR[3]: waddr <= old A[14:0], wdata <= `alu_out`.
    - jump = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr).
    - PC <= jump ? old A[14:0] : PC+1.
    - Next state is MWRITE if IR[3]=1, else FETCH.
  - MWRITE: `dmem_req`=1, `dmem_we`=1, with waddr and wdata presented. On ack go to FETCH.
  - HALT: only reachable when the macro is defined.
- "Old A" means the A value before this edge. A, D and PC update on the same edge.
- PC increment wraps from 0x7FFF to 0x0000. IR[14:13] are ignored.
- `dmem_addr`, `dmem_we` and `dmem_wdata` are stable while `dmem_req`=1. `dmem_req`=0 in all other states; `dmem_addr`/`dmem_wdata` are don't-care then.
- An ack arriving in the same cycle as the req is legal and completes the transfer in one cycle.

## Timing
- Reset values: state=FETCH; PC, A, D, IR, M_reg, waddr, wdata all 0; `dmem_req`=0, `dmem_we`=0, `halted`=0. ALU control outputs are therefore all 0.
- Reset asserted mid-MREAD or mid-MWRITE drops `dmem_req` on the next cycle; any pending ack is ignored.
- Latency in cycles:
  - A-instruction: 2.
  - C-instruction without memory: 3.
  - Add (1 + ack wait) for each of MREAD and MWRITE.
- The ALU path is combinational within EXECUTE. `alu_out`, `alu_zr` and `alu_ng` must settle within that cycle.

## Configuration
- `HACK_CPU_HALT_DETECT_EN` defined: if EXECUTE takes a jump whose target equals the jump's own PC, the FSM enters HALT.
  - In HALT: `halted`=1, PC, A and D are frozen, no fetch occurs, `dmem_req`=0.
  - Only `reset` exits HALT.
  - Any MWRITE owed by the halting instruction completes first; HALT is then entered instead of FETCH.
- Macro undefined: the HALT state is absent, `halted` is tied 0, and self-loops execute indefinitely.

## Test plan
- Reset, then `instr`=0x0005 at PC 0 -> after 2 cycles A=0x0005, PC=1, `dmem_req` never asserted.
- Program @5 then 0xEC10 (D=A) -> in EXECUTE the ALU controls read zx=1 nx=1 zy=0 ny=0 f=0 no=0; then D=5 and PC=2.
- D=5, @7, 0xE308 (M=D), with ack delayed 3 cycles -> `dmem_req`=1, `dmem_we`=1, addr=7, wdata=5 held stable for 4 cycles; then FETCH.
- @7, 0xFC10 (D=M), `dmem_rdata`=0x1234 with same-cycle ack -> MREAD lasts 1 cycle; D=0x1234.
- Jumps:
  - @10, 0xEA87 (0;JMP) -> PC=10.
  - With D=0, 0xE302 (D;JEQ) -> jump taken.
  - With D=5, 0xE302 -> PC+1.
  - Reset asserted during MWRITE -> next cycle `dmem_req`=0 and PC=0.
- @3 at PC 2, then 0xEA87 at PC 3:
  - Macro defined -> `halted`=1 and PC stays 3.
  - Macro undefined -> `halted`=0 and PC=3 is refetched indefinitely.
